dadda_prod_acc: RTL



---
 rtl/dadda_pkg.sv | 15 +
 rtl/dadda_prod_acc_if.sv | 26 ++
 rtl/dadda_sat_add.sv | 18 +
 rtl/dadda_prod_acc.sv | 86 ++++++++
 4 files changed

// File: rtl/dadda_pkg.sv
// dadda_pkg: shared state type, multiplier widths and the saturating/wrapping add helper
package dadda_pkg;
    localparam int MUL_BIT = 8;
    localparam int PROD_W  = 2 * MUL_BIT;
    localparam int MAX_W   = 64;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

    // sum is an (acc_w+1)-bit result zero-extended; anything above the all-ones limit is a carry
    function automatic logic [MAX_W-1:0] sat_wrap(input logic [MAX_W:0] sum, input int acc_w, input bit sat);
        logic [MAX_W:0] lim;
        lim = ({{MAX_W{1'b0}}, 1'b1} << acc_w) - (MAX_W+1)'(1);
        return (sat && (sum > lim)) ? lim[MAX_W-1:0] : (sum[MAX_W-1:0] & lim[MAX_W-1:0]);
    endfunction
endpackage

// File: rtl/dadda_prod_acc_if.sv
// dadda_prod_acc_if: product beat input and accumulated result output handshakes
interface dadda_prod_acc_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, clr, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_prod, in_last, clr, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/dadda_sat_add.sv
// dadda_sat_add: ACC_W-bit adder with carry out and optional clamp to all-ones
module dadda_sat_add
    import dadda_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             carry_o
);
    logic [ACC_W:0] raw;

    assign raw     = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = raw[ACC_W];
    assign sum_o   = ACC_W'(sat_wrap((MAX_W+1)'(raw), ACC_W, SATURATE));
endmodule

// File: rtl/dadda_prod_acc.sv
// dadda_prod_acc: accumulates groups of multiplier products and presents
// the registered sum, beat count and overflow flag on a valid/ready port
module dadda_prod_acc
    import dadda_pkg::*;
#(
    parameter int PROD_W   = 2 * MUL_BIT,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    dadda_prod_acc_if.slave bus
);
    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, sum_q, sum_d, add_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d, count_q, count_d, cnt_nx;
    logic              ovf_q, ovf_d, oovf_q, oovf_d, ovf_nx, carry, accept, fin;
    logic [PROD_W-1:0] prod;

    assign prod          = bus.in_prod;
    assign bus.in_ready  = (state_q != HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_sum   = sum_q;
    assign bus.out_count = count_q;
    assign bus.out_ovf   = oovf_q;

    dadda_sat_add #(.ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
        .a_i    (acc_q),
        .b_i    (ACC_W'(prod)),
        .sum_o  (add_sum),
        .carry_o(carry)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign fin    = accept && bus.in_last;
    // a beat arriving with the counter already full is itself a count overflow
    assign cnt_nx = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign ovf_nx = ovf_q | carry | (&cnt_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        count_d = count_q;
        oovf_d  = oovf_q;
        if (state_q == HOLD) begin
            state_d = bus.out_ready ? IDLE : HOLD;
        end else if (bus.clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            state_d = fin ? HOLD : ACCUM;
            acc_d   = fin ? '0 : add_sum;
            cnt_d   = fin ? '0 : cnt_nx;
            ovf_d   = fin ? 1'b0 : ovf_nx;
            sum_d   = fin ? add_sum : sum_q;
            count_d = fin ? cnt_nx : count_q;
            oovf_d  = fin ? ovf_nx : oovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            oovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            oovf_q  <= oovf_d;
        end
    end
endmodule
